// File: rtl/dbg_cmd_bridge.sv
// dbg_cmd_bridge: framed byte-stream to debug register bus bridge with byte responses
module dbg_cmd_bridge #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_drop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  dbg_a,
  output logic [15:0] dbg_di,
  input  logic [15:0] dbg_do,
  output logic        dbg_we,
  output logic        dbg_rd,
  input  logic        dbg_ready,
  output logic        busy
);
  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DLO, GET_DHI, GET_CNT, ACCESS, RESP_LO, RESP_HI, RESP_ONE
  } state_t;
  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [7:0]        a_q, a_d, hi_q, hi_d, tx_data_q, tx_data_d;
  logic [15:0]       di_q, di_d;
  logic              we_q, we_d, rd_q, rd_d, tx_valid_q, tx_valid_d, rx_drop_q, rx_drop_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    a_d = a_q;
    di_d = di_q;
    hi_d = hi_q;
    we_d = we_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    to_d = to_q;
    tx_valid_d = tx_valid_q;
    tx_data_d = tx_data_q;
    rx_drop_d = 1'b0;
    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data == 8'h01 || rx_data == 8'h02 || rx_data == 8'h03) begin
          state_d = GET_ADDR;
          cmd_d = rx_data[1:0];
        end else begin
          state_d = RESP_ONE;
          tx_data_d = 8'hEF;
        end
      end
      GET_ADDR: if (rx_valid) begin
        a_d = rx_data;
        if (cmd_q == 2'd1) state_d = GET_DLO;
        else if (cmd_q == 2'd3) state_d = GET_CNT;
        else begin
          state_d = ACCESS;
          rd_d = 1'b1;
          cnt_d = 9'd1;
          to_d = '0;
        end
      end
      GET_DLO: if (rx_valid) begin
        di_d[7:0] = rx_data;
        state_d = GET_DHI;
      end
      GET_DHI: if (rx_valid) begin
        di_d[15:8] = rx_data;
        state_d = ACCESS;
        we_d = 1'b1;
        to_d = '0;
      end
      GET_CNT: if (rx_valid) begin
        cnt_d = {rx_data == 8'h00, rx_data};
        state_d = ACCESS;
        rd_d = 1'b1;
        to_d = '0;
      end
      ACCESS: begin
        rx_drop_d = rx_valid;
        if (dbg_ready) begin
          we_d = 1'b0;
          rd_d = 1'b0;
          state_d = rd_q ? RESP_LO : RESP_ONE;
          tx_data_d = rd_q ? dbg_do[7:0] : 8'hA5;
          hi_d = rd_q ? dbg_do[15:8] : hi_q;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          we_d = 1'b0;
          rd_d = 1'b0;
          cnt_d = '0;
          state_d = RESP_ONE;
          tx_data_d = 8'hEE;
        end else to_d = to_q + 1'b1;
      end
      default: begin
        rx_drop_d = rx_valid;
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (state_q == RESP_LO) begin
            state_d = RESP_HI;
            tx_data_d = hi_q;
          end else if (state_q == RESP_HI) begin
            cnt_d = cnt_q - 9'd1;
            state_d = (cnt_q != 9'd1) ? ACCESS : IDLE;
            rd_d = cnt_q != 9'd1;
            to_d = '0;
          end else state_d = IDLE;
        end else tx_valid_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q <= '0;
      a_q <= '0;
      di_q <= '0;
      hi_q <= '0;
      we_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= '0;
      to_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q <= '0;
      rx_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      a_q <= a_d;
      di_q <= di_d;
      hi_q <= hi_d;
      we_q <= we_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q <= tx_data_d;
      rx_drop_q <= rx_drop_d;
    end
  end
  assign dbg_a = a_q;
  assign dbg_di = di_q;
  assign dbg_we = we_q;
  assign dbg_rd = rd_q;
  assign tx_valid = tx_valid_q;
  assign tx_data = tx_data_q;
  assign rx_drop = rx_drop_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// tb_dbg_cmd_bridge: directed self-checking bench for dbg_cmd_bridge
module tb_dbg_cmd_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_drop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  dbg_a;
  logic [15:0] dbg_di;
  logic [15:0] dbg_do;
  logic        dbg_we;
  logic        dbg_rd;
  logic        dbg_ready;
  logic        busy;
  int n_assert = 0;
  int n_fail = 0;
  int mode = 0;
  logic [15:0] do_base = 16'h0;
  logic [15:0] do_step = 16'h0;
  int tx_n = 0, rd_cyc = 0, we_cyc = 0, rd_rdy = 0, rdy = 0, rd_rise = 0, dcnt = 0;
  int tx_mark, rd_mark, we_mark, rdrdy_mark, rdy_mark, rise_mark;
  logic prev_rd = 1'b0;
  logic [7:0] txbuf [0:2047];
  dbg_cmd_bridge #(.TIMEOUT(1000), .TO_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_drop(rx_drop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_a(dbg_a), .dbg_di(dbg_di), .dbg_do(dbg_do), .dbg_we(dbg_we), .dbg_rd(dbg_rd),
    .dbg_ready(dbg_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  assign dbg_ready = mode == 0 ? (dbg_a[7:4] == 4'h1 && dbg_we) :
                     mode == 1 ? 1'b1 :
                     mode == 2 ? (dbg_rd && dcnt == 5) : 1'b0;
  assign dbg_do = do_base + do_step * 16'(rd_rdy - rdrdy_mark);
  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      if (tx_n < 2048) txbuf[tx_n] <= tx_data;
      tx_n <= tx_n + 1;
    end
    rd_cyc <= rd_cyc + int'(dbg_rd);
    we_cyc <= we_cyc + int'(dbg_we);
    rd_rdy <= rd_rdy + int'(dbg_rd && dbg_ready);
    rdy <= rdy + int'((dbg_rd || dbg_we) && dbg_ready);
    rd_rise <= rd_rise + int'(dbg_rd && !prev_rd);
    prev_rd <= dbg_rd;
    dcnt <= (dbg_rd && !dbg_ready) ? dcnt + 1 : 0;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic mark();
    tx_mark = tx_n;
    rd_mark = rd_cyc;
    we_mark = we_cyc;
    rdrdy_mark = rd_rdy;
    rdy_mark = rdy;
    rise_mark = rd_rise;
  endtask
  task automatic wait_tx(input int n, input int budget);
    int t = 0;
    while (tx_n - tx_mark < n && t < budget) begin
      tick();
      t++;
    end
    chk("tx_count", tx_n - tx_mark, n);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 0);
    chk({tag, "_dbg_a"}, {24'd0, dbg_a}, 0);
    chk({tag, "_dbg_di"}, {16'd0, dbg_di}, 0);
    chk({tag, "_strobes"}, {30'd0, dbg_we, dbg_rd}, 0);
    chk({tag, "_rx_drop"}, {31'd0, rx_drop}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h0;
    tx_ready = 1'b1;
    tick();
    tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    mode = 0;
    mark();
    send(8'h01);
    chk("wr_busy", {31'd0, busy}, 1);
    send(8'h1B);
    send(8'h34);
    send(8'h12);
    chk("wr_we", {31'd0, dbg_we}, 1);
    chk("wr_a", {24'd0, dbg_a}, 32'h1B);
    chk("wr_di", {16'd0, dbg_di}, 32'h1234);
    wait_tx(1, 50);
    chk("wr_ack", {24'd0, txbuf[tx_mark]}, 32'hA5);
    chk("wr_we_cycles", we_cyc - we_mark, 1);
    chk("wr_ready_cycles", rdy - rdy_mark, 1);
    chk("wr_idle", {31'd0, busy}, 0);
    mode = 1;
    do_base = 16'hBEEF;
    do_step = 16'h0;
    mark();
    send(8'h02);
    send(8'h1A);
    chk("rd_rd", {31'd0, dbg_rd}, 1);
    chk("rd_a", {24'd0, dbg_a}, 32'h1A);
    wait_tx(2, 50);
    chk("rd_lo", {24'd0, txbuf[tx_mark]}, 32'hEF);
    chk("rd_hi", {24'd0, txbuf[tx_mark+1]}, 32'hBE);
    chk("rd_cycles", rd_cyc - rd_mark, 1);
    mode = 2;
    do_base = 16'h1111;
    do_step = 16'h1111;
    mark();
    send(8'h03);
    send(8'h20);
    send(8'h03);
    wait_tx(6, 300);
    for (int i = 0; i < 6; i++)
      chk("burst_byte", {24'd0, txbuf[tx_mark+i]}, {24'd0, 8'(8'h11 * (i / 2 + 1))});
    chk("burst_rises", rd_rise - rise_mark, 3);
    chk("burst_ready", rdy - rdy_mark, 3);
    chk("burst_rd_cycles", rd_cyc - rd_mark, 18);
    tick();
    chk("burst_idle", {30'd0, busy, dbg_rd}, 0);
    mode = 3;
    mark();
    send(8'h02);
    send(8'h05);
    wait_tx(1, 1100);
    chk("to_code", {24'd0, txbuf[tx_mark]}, 32'hEE);
    chk("to_rd_cycles", rd_cyc - rd_mark, 1000);
    chk("to_no_ready", rdy - rdy_mark, 0);
    chk("to_idle", {30'd0, busy, dbg_rd}, 0);
    mode = 1;
    do_base = 16'h5A3C;
    do_step = 16'h0;
    mark();
    send(8'h02);
    send(8'h11);
    wait_tx(2, 50);
    chk("post_to_lo", {24'd0, txbuf[tx_mark]}, 32'h3C);
    chk("post_to_hi", {24'd0, txbuf[tx_mark+1]}, 32'h5A);
    mark();
    send(8'h7F);
    wait_tx(1, 50);
    chk("bad_cmd", {24'd0, txbuf[tx_mark]}, 32'hEF);
    do_base = 16'hC0DE;
    tx_ready = 1'b0;
    mark();
    send(8'h02);
    send(8'h33);
    tick();
    tick();
    tick();
    chk("hold_valid", {31'd0, tx_valid}, 1);
    chk("hold_data", {24'd0, tx_data}, 32'hDE);
    send(8'h01);
    chk("drop_pulse", {31'd0, rx_drop}, 1);
    tick();
    chk("drop_end", {31'd0, rx_drop}, 0);
    chk("drop_data", {23'd0, tx_valid, tx_data}, 32'h1DE);
    tx_ready = 1'b1;
    wait_tx(2, 50);
    chk("drop_lo", {24'd0, txbuf[tx_mark]}, 32'hDE);
    chk("drop_hi", {24'd0, txbuf[tx_mark+1]}, 32'hC0);
    chk("drop_idle", {31'd0, busy}, 0);
    do_base = 16'h0;
    do_step = 16'h1;
    mark();
    send(8'h03);
    send(8'h20);
    send(8'h00);
    wait_tx(512, 3000);
    chk("b256_rises", rd_rise - rise_mark, 256);
    chk("b256_byte2", {24'd0, txbuf[tx_mark+2]}, 32'h01);
    chk("b256_last_lo", {24'd0, txbuf[tx_mark+510]}, 32'hFF);
    chk("b256_last_hi", {24'd0, txbuf[tx_mark+511]}, 32'h00);
    tick();
    chk("b256_idle", {31'd0, busy}, 0);
    mark();
    send(8'h03);
    send(8'h20);
    send(8'h00);
    for (int i = 0; i < 100; i++) tick();
    chk("mid_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    tick();
    chk_reset("midrst");
    rst_n = 1'b1;
    tick();
    mark();
    send(8'h55);
    wait_tx(1, 50);
    chk("after_rst", {24'd0, txbuf[tx_mark]}, 32'hEF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
